mpram_lvt: RTL and testbench

Parametrised multi-port RAM with NB_WRAGENT write ports and NB_RDAGENT read ports, built from 1W1R banks plus a live-value table (LVT). The LVT records which write agent last wrote each address. It generalises the fixed 2W/2R top with the following additions:
- configurable port counts
- deterministic write-collision resolution
- selectable read-during-write mode
- optional zero-initialisation FSM after reset
- per-port read-valid
It sits between agent request logic and shared storage.

---
 rtl/mpram_lvt.sv | 223 ++++++++++++++++++++++
 tb/tb_mpram_lvt.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpram_lvt.sv
// ---------------------------------------------------------------------------
// mpram_lvt -- multi-port RAM built from 1W1R banks plus a live-value table.
//
// NB_WRAGENT write ports and NB_RDAGENT read ports share one logical memory.
// Each write agent i owns a row of banks (i, 0..NB_RDAGENT-1), one bank per
// read agent, so every bank has exactly one writer and one reader. The LVT
// records, per address, which write agent wrote it last; a read port uses
// that entry to pick its bank.
//
// Ports:
//   aclk, aresetn  clock and asynchronous active-low reset
//   init_done      1 once memory zeroing has finished and traffic is accepted
//   wren/wraddr/wrdata  per-agent write request (flattened, agent i at slice i)
//   wrcollision    registered; bit i = agent i lost an address collision
//   rden/rdaddr    per-agent read request (flattened)
//   rddata         registered read data, one cycle after rden, holds otherwise
//   rdvalid        bit k = rddata slice k carries the result of a read
//   rdcollision    bit k = the returned read overlapped a same-address write
// ---------------------------------------------------------------------------
module mpram_lvt #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned RAM_DEPTH     = 2**ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_WRAGENT    = 2,
  parameter int unsigned NB_RDAGENT    = 2,
  parameter int unsigned RDW_MODE      = 0,
  parameter int unsigned INIT_ON_RESET = 1,
  localparam int unsigned LVT_WIDTH    = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT)
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  output logic                             init_done,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
  output logic [NB_WRAGENT-1:0]            wrcollision,
  input  logic [NB_RDAGENT-1:0]            rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
  output logic [NB_RDAGENT*DATA_WIDTH-1:0] rddata,
  output logic [NB_RDAGENT-1:0]            rdvalid,
  output logic [NB_RDAGENT-1:0]            rdcollision
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q;
  logic                  run;
  logic                  init_we;

  logic [ADDR_WIDTH-1:0] wr_addr [NB_WRAGENT];
  logic [DATA_WIDTH-1:0] wr_data [NB_WRAGENT];
  logic [ADDR_WIDTH-1:0] rd_addr [NB_RDAGENT];

  logic [NB_WRAGENT-1:0] wr_lose;
  logic [NB_WRAGENT-1:0] wr_win;
  logic [NB_WRAGENT-1:0] wrcoll_q, wrcoll_d;

  logic [LVT_WIDTH-1:0]  lvt_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] bank_rd [NB_WRAGENT][NB_RDAGENT];

  logic [DATA_WIDTH-1:0] rddata_q [NB_RDAGENT];
  logic [DATA_WIDTH-1:0] rddata_d [NB_RDAGENT];
  logic [NB_RDAGENT-1:0] rdvalid_q, rdvalid_d;
  logic [NB_RDAGENT-1:0] rdcoll_q, rdcoll_d;

  // Traffic is accepted only once init_done is visible outside, so the
  // first accepted cycle is the one after init_done rises.
  assign run     = init_done_q;
  assign init_we = (state_q == ST_INIT);

  // -------------------------------------------------------------------------
  // Port unpacking
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NB_WRAGENT; gi++) begin : g_wunpack
    assign wr_addr[gi] = wraddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data[gi] = wrdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar gk = 0; gk < NB_RDAGENT; gk++) begin : g_rpack
    assign rd_addr[gk]                        = rdaddr[gk*ADDR_WIDTH +: ADDR_WIDTH];
    assign rddata[gk*DATA_WIDTH +: DATA_WIDTH] = rddata_q[gk];
  end

  assign init_done   = init_done_q;
  assign wrcollision = wrcoll_q;
  assign rdvalid     = rdvalid_q;
  assign rdcollision = rdcoll_q;

  // -------------------------------------------------------------------------
  // Zero-initialisation FSM: walks every address once, then stays in RUN.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Write arbitration: an agent loses if any lower-indexed enabled agent
  // targets the same address. Winners therefore always hit distinct addresses.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_lose = '0;
    for (int unsigned i = 1; i < NB_WRAGENT; i++) begin
      for (int unsigned j = 0; j < i; j++) begin
        if (wren[i] && wren[j] && (wr_addr[i] == wr_addr[j])) begin
          wr_lose[i] = 1'b1;
        end
      end
    end
    wr_win   = run ? (wren & ~wr_lose) : '0;
    wrcoll_d = run ? (wren &  wr_lose) : '0;
  end

  // -------------------------------------------------------------------------
  // Live-value table
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned a = 0; a < RAM_DEPTH; a++) begin
        lvt_q[a] <= '0;
      end
    end else if (init_we) begin
      lvt_q[cnt_q] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
        if (wr_win[i]) begin
          lvt_q[wr_addr[i]] <= LVT_WIDTH'(i);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // 1W1R banks: bank (i,k) written by write agent i, read by read agent k.
  // Storage itself is not reset; the INIT walk clears it.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NB_WRAGENT; gi++) begin : g_wr
    for (genvar gk = 0; gk < NB_RDAGENT; gk++) begin : g_rd
      logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

      always_ff @(posedge aclk) begin
        if (init_we) begin
          mem_q[cnt_q] <= '0;
        end else if (wr_win[gi]) begin
          mem_q[wr_addr[gi]] <= wr_data[gi];
        end
      end

      assign bank_rd[gi][gk] = mem_q[rd_addr[gk]];
    end
  end

  // -------------------------------------------------------------------------
  // Read path: LVT selects the bank using pre-edge state; the selected word
  // is registered. With RDW_MODE=1 the winning same-address write is
  // forwarded instead. Ascending scan with a found flag picks the lowest
  // enabled agent, which is the collision winner.
  // -------------------------------------------------------------------------
  always_comb begin
    rdvalid_d = '0;
    rdcoll_d  = '0;
    for (int unsigned k = 0; k < NB_RDAGENT; k++) begin
      logic found;
      found       = 1'b0;
      rddata_d[k] = rddata_q[k];
      if (run && rden[k]) begin
        rdvalid_d[k] = 1'b1;
        rddata_d[k]  = bank_rd[lvt_q[rd_addr[k]]][k];
        for (int unsigned j = 0; j < NB_WRAGENT; j++) begin
          if (wren[j] && (wr_addr[j] == rd_addr[k])) begin
            rdcoll_d[k] = 1'b1;
            if ((RDW_MODE == 1) && !found) begin
              rddata_d[k] = wr_data[j];
            end
            found = 1'b1;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      wrcoll_q    <= '0;
      rdvalid_q   <= '0;
      rdcoll_q    <= '0;
      for (int unsigned k = 0; k < NB_RDAGENT; k++) begin
        rddata_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_q == ST_RUN);
      wrcoll_q    <= wrcoll_d;
      rdvalid_q   <= rdvalid_d;
      rdcoll_q    <= rdcoll_d;
      for (int unsigned k = 0; k < NB_RDAGENT; k++) begin
        rddata_q[k] <= rddata_d[k];
      end
    end
  end

endmodule

// File: tb/tb_mpram_lvt.sv
// ---------------------------------------------------------------------------
// tb_mpram_lvt -- two instances (old-data and bypass read-during-write) of a
// 4W/3R mpram_lvt driven by identical stimulus. A single-array memory model
// predicts every output each cycle; directed sequences add literal checks.
// ---------------------------------------------------------------------------
module tb_mpram_lvt;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned NW    = 4;
  localparam int unsigned NR    = 3;

  logic              aclk;
  logic              aresetn;
  logic [NW-1:0]     wren;
  logic [NW*AW-1:0]  wraddr;
  logic [NW*DW-1:0]  wrdata;
  logic [NR-1:0]     rden;
  logic [NR*AW-1:0]  rdaddr;

  logic              init_done0, init_done1;
  logic [NW-1:0]     wrcoll0, wrcoll1;
  logic [NR*DW-1:0]  rddata0, rddata1;
  logic [NR-1:0]     rdvalid0, rdvalid1;
  logic [NR-1:0]     rdcoll0, rdcoll1;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  bit          cmp_en   = 1'b0;

  mpram_lvt #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW),
    .NB_WRAGENT(NW), .NB_RDAGENT(NR), .RDW_MODE(0), .INIT_ON_RESET(1)
  ) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .init_done(init_done0),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .wrcollision(wrcoll0),
    .rden(rden), .rdaddr(rdaddr), .rddata(rddata0),
    .rdvalid(rdvalid0), .rdcollision(rdcoll0)
  );

  mpram_lvt #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW),
    .NB_WRAGENT(NW), .NB_RDAGENT(NR), .RDW_MODE(1), .INIT_ON_RESET(1)
  ) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .init_done(init_done1),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .wrcollision(wrcoll1),
    .rden(rden), .rdaddr(rdaddr), .rddata(rddata1),
    .rdvalid(rdvalid1), .rdcollision(rdcoll1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (actual timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: one logical memory, last accepted winner's data wins.
  // -------------------------------------------------------------------------
  logic [DW-1:0] mdl_mem [DEPTH];
  int unsigned   edges;
  logic          exp_init_done;
  logic [NW-1:0] exp_wrcoll;
  logic [NR-1:0] exp_rdvalid, exp_rdcoll;
  logic [DW-1:0] exp_rd0 [NR];
  logic [DW-1:0] exp_rd1 [NR];

  always @(posedge aclk or negedge aresetn) begin : model
    bit            accept, hit, lose;
    logic [AW-1:0] a;
    logic [DW-1:0] byp;
    if (!aresetn) begin
      edges         = 0;
      exp_init_done = 1'b0;
      exp_wrcoll    = '0;
      exp_rdvalid   = '0;
      exp_rdcoll    = '0;
      for (int k = 0; k < NR; k++) begin
        exp_rd0[k] = '0;
        exp_rd1[k] = '0;
      end
      // INIT zeroes the whole memory before any traffic is accepted.
      for (int m = 0; m < DEPTH; m++) mdl_mem[m] = '0;
    end else begin
      accept = exp_init_done;
      edges++;
      if (edges >= DEPTH + 1) exp_init_done = 1'b1;
      for (int k = 0; k < NR; k++) begin
        exp_rdvalid[k] = 1'b0;
        exp_rdcoll[k]  = 1'b0;
        if (accept && rden[k]) begin
          a   = rdaddr[k*AW +: AW];
          hit = 1'b0;
          byp = mdl_mem[a];
          for (int j = 0; j < NW; j++) begin
            if (wren[j] && wraddr[j*AW +: AW] == a) begin
              if (!hit) byp = wrdata[j*DW +: DW];
              hit = 1'b1;
            end
          end
          exp_rdvalid[k] = 1'b1;
          exp_rdcoll[k]  = hit;
          exp_rd0[k]     = mdl_mem[a];
          exp_rd1[k]     = byp;
        end
      end
      for (int i = 0; i < NW; i++) begin
        lose = 1'b0;
        for (int j = 0; j < i; j++) begin
          if (wren[j] && wraddr[j*AW +: AW] == wraddr[i*AW +: AW]) lose = 1'b1;
        end
        exp_wrcoll[i] = accept && wren[i] && lose;
        if (accept && wren[i] && !lose) mdl_mem[wraddr[i*AW +: AW]] = wrdata[i*DW +: DW];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle comparison against the model (outputs are stable at negedge).
  // -------------------------------------------------------------------------
  always @(negedge aclk) begin
    if (cmp_en) begin
      chk("init_done_m0", 64'(init_done0), 64'(exp_init_done));
      chk("init_done_m1", 64'(init_done1), 64'(exp_init_done));
      chk("wrcoll_m0", 64'(wrcoll0), 64'(exp_wrcoll));
      chk("wrcoll_m1", 64'(wrcoll1), 64'(exp_wrcoll));
      chk("rdvalid_m0", 64'(rdvalid0), 64'(exp_rdvalid));
      chk("rdvalid_m1", 64'(rdvalid1), 64'(exp_rdvalid));
      chk("rdcoll_m0", 64'(rdcoll0), 64'(exp_rdcoll));
      chk("rdcoll_m1", 64'(rdcoll1), 64'(exp_rdcoll));
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("rddata_m0[%0d]", k), 64'(rddata0[k*DW +: DW]), 64'(exp_rd0[k]));
        chk($sformatf("rddata_m1[%0d]", k), 64'(rddata1[k*DW +: DW]), 64'(exp_rd1[k]));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the active edge)
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    wren = '0;
    rden = '0;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wren[i]            = 1'b1;
    wraddr[i*AW +: AW] = a;
    wrdata[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rden[k]            = 1'b1;
    rdaddr[k*AW +: AW] = a;
  endtask

  task automatic rand_inputs(input int unsigned amax);
    for (int i = 0; i < NW; i++) begin
      wren[i]            = 1'($urandom_range(0, 1));
      wraddr[i*AW +: AW] = AW'($urandom_range(0, amax));
      wrdata[i*DW +: DW] = $urandom();
    end
    for (int k = 0; k < NR; k++) begin
      rden[k]            = 1'($urandom_range(0, 1));
      rdaddr[k*AW +: AW] = AW'($urandom_range(0, amax));
    end
  endtask

  // Runs up to 40 edges with random traffic (rden forced high) and returns
  // the number of edges until init_done is seen on both instances.
  task automatic wait_init(output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      rand_inputs(15);
      rden = '1;
      step();
      n++;
      if (c == 4) chk("rdvalid_during_init", 64'(rdvalid0 | rdvalid1), 64'(0));
      if (init_done0 && init_done1) got = 1'b1;
    end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int n;
    aresetn = 1'b0;
    wren    = '0;
    wraddr  = '0;
    wrdata  = '0;
    rden    = '0;
    rdaddr  = '0;
    repeat (3) step();
    cmp_en = 1'b1;
    chk("reset_init_done", 64'(init_done0), 64'(0));
    chk("reset_rdvalid", 64'(rdvalid0), 64'(0));

    // Release between edges; count edges until init_done.
    aresetn = 1'b1;
    wait_init(n);
    chk("init_edges", 64'(n), 64'(17));

    // Every address reads zero after INIT, one cycle after rden.
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      for (int k = 0; k < NR; k++) set_rd(k, AW'(a));
      step();
      chk("init_zero_rd_m0", 64'(rddata0[0 +: DW]), 64'(0));
      chk("init_zero_rd_m1", 64'(rddata1[DW +: DW]), 64'(0));
      chk("init_zero_valid", 64'(rdvalid0), 64'(3'b111));
    end

    // Last writer to an address wins across agents.
    idle(); set_wr(0, 4'd3, 32'hA5A5A5A5); step();
    idle(); step();
    idle(); set_wr(1, 4'd3, 32'h12345678); step();
    idle(); set_rd(0, 4'd3); set_rd(1, 4'd3); step();
    chk("lastwr_p0", 64'(rddata0[0 +: DW]), 64'h12345678);
    chk("lastwr_p1", 64'(rddata0[DW +: DW]), 64'h12345678);

    // Same-cycle collision on addr5: agent0 wins, agent1 flagged for one cycle.
    idle(); set_wr(0, 4'd5, 32'h11); set_wr(1, 4'd5, 32'h22); step();
    chk("wrcoll_hit_m0", 64'(wrcoll0), 64'(4'b0010));
    chk("wrcoll_hit_m1", 64'(wrcoll1), 64'(4'b0010));
    idle(); set_rd(2, 4'd5); step();
    chk("wrcoll_clear", 64'(wrcoll0), 64'(0));
    chk("coll_winner_rd", 64'(rddata0[2*DW +: DW]), 64'h11);

    // Read-during-write on addr7.
    idle(); set_wr(0, 4'd7, 32'h33); step();
    idle(); set_wr(1, 4'd7, 32'h44); set_rd(0, 4'd7); step();
    chk("rdw_old_m0", 64'(rddata0[0 +: DW]), 64'h33);
    chk("rdw_new_m1", 64'(rddata1[0 +: DW]), 64'h44);
    chk("rdw_rdcoll_m0", 64'(rdcoll0[0]), 64'(1));
    chk("rdw_rdcoll_m1", 64'(rdcoll1[0]), 64'(1));
    idle(); set_rd(0, 4'd7); step();
    chk("rdw_after_m0", 64'(rddata0[0 +: DW]), 64'h44);
    chk("rdw_after_rdcoll", 64'(rdcoll0[0]), 64'(0));
    idle(); step();
    chk("hold_rddata", 64'(rddata0[0 +: DW]), 64'h44);
    chk("hold_rdvalid", 64'(rdvalid0), 64'(0));

    // Random traffic on all ports, narrow address range for overlaps.
    for (int c = 0; c < 200; c++) begin
      rand_inputs(7);
      step();
    end

    // Asynchronous reset mid-traffic.
    rand_inputs(7);
    aresetn = 1'b0;
    #1;
    chk("midrst_init_done", 64'({init_done0, init_done1}), 64'(0));
    chk("midrst_wrcoll", 64'({wrcoll0, wrcoll1}), 64'(0));
    chk("midrst_rdvalid", 64'({rdvalid0, rdvalid1}), 64'(0));
    chk("midrst_rdcoll", 64'({rdcoll0, rdcoll1}), 64'(0));
    chk("midrst_rddata0", 64'(rddata0[0 +: DW] | rddata0[DW +: DW] | rddata0[2*DW +: DW]), 64'(0));
    chk("midrst_rddata1", 64'(rddata1[0 +: DW] | rddata1[DW +: DW] | rddata1[2*DW +: DW]), 64'(0));
    repeat (3) step();
    aresetn = 1'b1;
    wait_init(n);
    chk("reinit_edges", 64'(n), 64'(17));
    idle(); set_rd(0, 4'd3); step();
    chk("reinit_rd3_m0", 64'(rddata0[0 +: DW]), 64'(0));
    chk("reinit_rd3_m1", 64'(rddata1[0 +: DW]), 64'(0));
    chk("reinit_rdvalid", 64'(rdvalid0), 64'(3'b001));

    // A bit more random traffic after re-initialisation.
    for (int c = 0; c < 40; c++) begin
      rand_inputs(15);
      step();
    end
    idle();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
